// File: rtl/reservation_station.sv
// Reservation station: holds non-memory ops until both operands are ready, then sends one per cycle to the ALU.
// Issue-to-exec latency is 2 cycles; issues arriving while rs_full is high are dropped, and rdy=0 freezes all state.
module reservation_station #(
    parameter int RS_SIZE = 16,
    parameter int RS_LOG  = 4,
    parameter int ROB_LOG = 4,
    parameter int OP_LOG  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rdy,
    input  logic               rollback,
    input  logic               issue_valid,
    input  logic [OP_LOG-1:0]  issue_op,
    input  logic [31:0]        issue_Vj,
    input  logic [31:0]        issue_Vk,
    input  logic               issue_Rj,
    input  logic               issue_Rk,
    input  logic [ROB_LOG-1:0] issue_Qj,
    input  logic [ROB_LOG-1:0] issue_Qk,
    input  logic [31:0]        issue_imm,
    input  logic [31:0]        issue_pc,
    input  logic [ROB_LOG-1:0] issue_RobId,
    input  logic               alu_valid,
    input  logic [ROB_LOG-1:0] alu_RobId,
    input  logic [31:0]        alu_value,
    input  logic               lsb_valid,
    input  logic [ROB_LOG-1:0] lsb_RobId,
    input  logic [31:0]        lsb_value,
    output logic               rs_full,
    output logic               exec_valid,
    output logic [OP_LOG-1:0]  exec_op,
    output logic [31:0]        exec_Vj,
    output logic [31:0]        exec_Vk,
    output logic [31:0]        exec_imm,
    output logic [31:0]        exec_pc,
    output logic [ROB_LOG-1:0] exec_RobId
);
    typedef struct packed {
        logic [OP_LOG-1:0]  op;
        logic [31:0]        vj;
        logic               rj;
        logic [ROB_LOG-1:0] qj;
        logic [31:0]        vk;
        logic               rk;
        logic [ROB_LOG-1:0] qk;
        logic [31:0]        imm;
        logic [31:0]        pc;
        logic [ROB_LOG-1:0] rob_id;
    } entry_t;

    logic [RS_SIZE-1:0] busy;
    entry_t             ent [RS_SIZE];
    entry_t             new_ent;
    logic [RS_LOG-1:0]  free_idx;
    logic [RS_LOG-1:0]  sel_idx;
    logic               has_free;
    logic               has_sel;

    assign rs_full = &busy;

    // Returns {ready, value}; the ALU bus takes priority over the LSB bus.
    function automatic logic [32:0] snoop(input logic r, input logic [ROB_LOG-1:0] q,
                                          input logic [31:0] v);
        if (r) return {1'b1, v};
        if (alu_valid && alu_RobId == q) return {1'b1, alu_value};
        if (lsb_valid && lsb_RobId == q) return {1'b1, lsb_value};
        return {1'b0, v};
    endfunction

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        free_idx = '0;
        has_free = 1'b0;
        sel_idx  = '0;
        has_sel  = 1'b0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = RS_LOG'(i);
                has_free = 1'b1;
            end
            if (busy[i] && ent[i].rj && ent[i].rk) begin
                sel_idx = RS_LOG'(i);
                has_sel = 1'b1;
            end
        end
    end

    always_comb begin
        new_ent                  = '0;
        new_ent.op               = issue_op;
        new_ent.qj               = issue_Qj;
        new_ent.qk               = issue_Qk;
        new_ent.imm              = issue_imm;
        new_ent.pc               = issue_pc;
        new_ent.rob_id           = issue_RobId;
        {new_ent.rj, new_ent.vj} = snoop(issue_Rj, issue_Qj, issue_Vj);
        {new_ent.rk, new_ent.vk} = snoop(issue_Rk, issue_Qk, issue_Vk);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            exec_valid <= 1'b0;
            exec_op    <= '0;
            exec_Vj    <= '0;
            exec_Vk    <= '0;
            exec_imm   <= '0;
            exec_pc    <= '0;
            exec_RobId <= '0;
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
        end else if (rdy) begin
            if (rollback) begin
                busy       <= '0;
                exec_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (busy[i]) begin
                        {ent[i].rj, ent[i].vj} <= snoop(ent[i].rj, ent[i].qj, ent[i].vj);
                        {ent[i].rk, ent[i].vk} <= snoop(ent[i].rk, ent[i].qk, ent[i].vk);
                    end
                end
                exec_valid <= has_sel;
                if (has_sel) begin
                    exec_op       <= ent[sel_idx].op;
                    exec_Vj       <= ent[sel_idx].vj;
                    exec_Vk       <= ent[sel_idx].vk;
                    exec_imm      <= ent[sel_idx].imm;
                    exec_pc       <= ent[sel_idx].pc;
                    exec_RobId    <= ent[sel_idx].rob_id;
                    busy[sel_idx] <= 1'b0;
                end
                // free_idx is never the dispatching slot: one is idle, the other busy.
                if (issue_valid && has_free) begin
                    ent[free_idx]  <= new_ent;
                    busy[free_idx] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic checked by a scoreboard.
module tb_reservation_station;
    localparam int RS_SIZE = 16;
    localparam int RS_LOG  = 4;
    localparam int ROB_LOG = 4;
    localparam int OP_LOG  = 6;

    logic clk = 1'b0;
    logic rst, rdy, rollback, issue_valid, issue_Rj, issue_Rk;
    logic [OP_LOG-1:0] issue_op;
    logic [31:0] issue_Vj, issue_Vk, issue_imm, issue_pc;
    logic [ROB_LOG-1:0] issue_Qj, issue_Qk, issue_RobId;
    logic alu_valid, lsb_valid;
    logic [ROB_LOG-1:0] alu_RobId, lsb_RobId;
    logic [31:0] alu_value, lsb_value;
    logic rs_full, exec_valid;
    logic [OP_LOG-1:0] exec_op;
    logic [31:0] exec_Vj, exec_Vk, exec_imm, exec_pc;
    logic [ROB_LOG-1:0] exec_RobId;

    reservation_station #(.RS_SIZE(RS_SIZE), .RS_LOG(RS_LOG), .ROB_LOG(ROB_LOG), .OP_LOG(OP_LOG)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_Vj(issue_Vj), .issue_Vk(issue_Vk),
        .issue_Rj(issue_Rj), .issue_Rk(issue_Rk), .issue_Qj(issue_Qj), .issue_Qk(issue_Qk),
        .issue_imm(issue_imm), .issue_pc(issue_pc), .issue_RobId(issue_RobId),
        .alu_valid(alu_valid), .alu_RobId(alu_RobId), .alu_value(alu_value),
        .lsb_valid(lsb_valid), .lsb_RobId(lsb_RobId), .lsb_value(lsb_value),
        .rs_full(rs_full), .exec_valid(exec_valid), .exec_op(exec_op), .exec_Vj(exec_Vj),
        .exec_Vk(exec_Vk), .exec_imm(exec_imm), .exec_pc(exec_pc), .exec_RobId(exec_RobId)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit busy;
        bit rj, rk;
        logic [OP_LOG-1:0] op;
        logic [31:0] vj, vk, imm, pc;
        logic [ROB_LOG-1:0] qj, qk, rob;
    } slot_t;

    typedef struct packed {
        logic [OP_LOG-1:0] op;
        logic [31:0] vj, vk, imm, pc;
        logic [ROB_LOG-1:0] rob;
    } xrec_t;

    slot_t m [RS_SIZE];
    xrec_t expq [$];
    xrec_t held;
    bit    exp_vld;
    bit    last_rdy;
    int    checks = 0;
    int    passed = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit model_full();
        for (int i = 0; i < RS_SIZE; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void resolve(input bit r, input logic [ROB_LOG-1:0] q, input logic [31:0] v,
                                    output bit ro, output logic [31:0] vo);
        ro = r;
        vo = v;
        if (!r) begin
            if (alu_valid && alu_RobId == q) begin ro = 1'b1; vo = alu_value; end
            else if (lsb_valid && lsb_RobId == q) begin ro = 1'b1; vo = lsb_value; end
        end
    endfunction

    // Reference model: decisions use the pool as it stood before the edge.
    always @(posedge clk or posedge rst) begin : model
        int d, f;
        bit r;
        logic [31:0] v;
        slot_t s;
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
            exp_vld = 1'b0;
            expq.delete();
        end else if (rdy) begin
            if (rollback) begin
                for (int i = 0; i < RS_SIZE; i++) m[i].busy = 1'b0;
                exp_vld = 1'b0;
            end else begin
                d = -1;
                f = -1;
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (d < 0 && m[i].busy && m[i].rj && m[i].rk) d = i;
                    if (f < 0 && !m[i].busy) f = i;
                end
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (m[i].busy) begin
                        resolve(m[i].rj, m[i].qj, m[i].vj, r, v); m[i].rj = r; m[i].vj = v;
                        resolve(m[i].rk, m[i].qk, m[i].vk, r, v); m[i].rk = r; m[i].vk = v;
                    end
                end
                exp_vld = (d >= 0);
                if (d >= 0) begin
                    expq.push_back('{m[d].op, m[d].vj, m[d].vk, m[d].imm, m[d].pc, m[d].rob});
                    m[d].busy = 1'b0;
                end
                if (issue_valid && f >= 0) begin
                    s.busy = 1'b1;
                    s.op = issue_op; s.imm = issue_imm; s.pc = issue_pc; s.rob = issue_RobId;
                    s.qj = issue_Qj; s.qk = issue_Qk;
                    resolve(issue_Rj, issue_Qj, issue_Vj, r, v); s.rj = r; s.vj = v;
                    resolve(issue_Rk, issue_Qk, issue_Vk, r, v); s.rk = r; s.vk = v;
                    m[f] = s;
                end
            end
        end
    end

    always @(posedge clk) last_rdy = rdy;

    // Monitor: compares DUT outputs with the scoreboard away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("exec_valid", exec_valid, exp_vld);
            check("rs_full", rs_full, model_full());
            if (last_rdy && expq.size() > 0) begin
                held = expq.pop_front();
                check("exec_payload", {exec_op, exec_Vj, exec_Vk, exec_imm, exec_pc, exec_RobId}, held);
            end else if (exec_valid && !last_rdy) begin
                check("exec_hold", {exec_op, exec_Vj, exec_Vk, exec_imm, exec_pc, exec_RobId}, held);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy = 1'b1; rollback = 1'b0; issue_valid = 1'b0;
        alu_valid = 1'b0; lsb_valid = 1'b0;
    endtask

    task automatic put(input logic [31:0] vj, input logic rj, input logic [3:0] qj,
                       input logic [31:0] vk, input logic rk, input logic [3:0] qk,
                       input logic [3:0] rob, input logic [31:0] pc);
        issue_valid = 1'b1; issue_op = 6'd1; issue_imm = 32'd0;
        issue_Vj = vj; issue_Rj = rj; issue_Qj = qj;
        issue_Vk = vk; issue_Rk = rk; issue_Qk = qk;
        issue_RobId = rob; issue_pc = pc;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        put(0, 0, 0, 0, 0, 0, 0, 0);
        issue_valid = 1'b0;
        alu_RobId = '0; alu_value = '0; lsb_RobId = '0; lsb_value = '0;
        tick(); tick();
        check("rst_exec_valid", exec_valid, 1'b0);
        check("rst_rs_full", rs_full, 1'b0);
        check("rst_exec_fields", {exec_op, exec_Vj, exec_Vk, exec_imm, exec_pc, exec_RobId}, 160'd0);
        rst = 1'b0;
        tick();

        // Ready ADD: exec_valid only in cycle 2.
        put(5, 1, 0, 7, 1, 0, 3, 32'h100);
        tick(); idle();
        check("add_cycle1", exec_valid, 1'b0);
        tick();
        check("add_cycle2_valid", exec_valid, 1'b1);
        check("add_fields", {exec_Vj, exec_Vk, exec_RobId, exec_pc}, {32'd5, 32'd7, 4'd3, 32'h100});
        tick();
        check("add_cycle3", exec_valid, 1'b0);

        // Wakeup via ALU bus in cycle 4 -> dispatch in cycle 6.
        put(0, 0, 5, 1, 1, 0, 4, 32'h104);
        tick(); idle(); tick(); tick(); tick();
        alu_valid = 1'b1; alu_RobId = 4'd5; alu_value = 32'h1234;
        tick(); idle();
        check("wake_cycle5", exec_valid, 1'b0);
        tick();
        check("wake_cycle6_valid", exec_valid, 1'b1);
        check("wake_vj", exec_Vj, 32'h1234);

        // Issue-time bypass from the LSB bus.
        tick();
        put(0, 0, 2, 9, 1, 0, 6, 32'h108);
        lsb_valid = 1'b1; lsb_RobId = 4'd2; lsb_value = 32'hDEAD;
        tick(); idle();
        check("bypass_cycle1", exec_valid, 1'b0);
        tick();
        check("bypass_valid", exec_valid, 1'b1);
        check("bypass_vj", exec_Vj, 32'hDEAD);
        tick();

        // Fill, drop the 17th, then release all in entry order.
        for (int i = 0; i < RS_SIZE; i++) begin
            put(0, 0, 7, 32'(i), 1, 0, 4'(i), 32'(i * 4));
            tick();
        end
        check("full_after_fill", rs_full, 1'b1);
        put(0, 1, 0, 0, 1, 0, 4'hF, 32'hBAD);
        tick(); idle();
        check("full_after_drop", rs_full, 1'b1);
        alu_valid = 1'b1; alu_RobId = 4'd7; alu_value = 32'h77;
        tick(); idle();
        check("full_before_dispatch", rs_full, 1'b1);
        for (int i = 0; i < RS_SIZE; i++) begin
            tick();
            check("drain_valid", exec_valid, 1'b1);
            check("drain_order_pc", exec_pc, 32'(i * 4));
            if (i == 0) check("full_falls", rs_full, 1'b0);
        end
        tick();
        check("drain_done", exec_valid, 1'b0);

        // Rollback overrides a same-cycle issue, broadcast and dispatch.
        for (int i = 0; i < 4; i++) begin
            put(0, 0, 9, 0, 1, 0, 4'(i), 32'h400 + 32'(i));
            tick();
        end
        put(1, 1, 0, 1, 1, 0, 4'd8, 32'h500);
        tick();
        put(2, 1, 0, 2, 1, 0, 4'd9, 32'h600);
        rollback = 1'b1; alu_valid = 1'b1; alu_RobId = 4'd9; alu_value = 32'h99;
        tick(); idle();
        check("rollback_no_exec", exec_valid, 1'b0);
        check("rollback_not_full", rs_full, 1'b0);
        tick();
        check("rollback_quiet", exec_valid, 1'b0);
        put(3, 1, 0, 4, 1, 0, 4'hA, 32'h200);
        tick(); idle(); tick();
        check("post_rollback_valid", exec_valid, 1'b1);
        check("post_rollback_pc", exec_pc, 32'h200);
        tick();

        // Two ready entries frozen by rdy=0, then released in order.
        put(0, 0, 11, 0, 1, 0, 4'd1, 32'h300);
        tick();
        put(0, 0, 11, 0, 1, 0, 4'd2, 32'h304);
        tick(); idle();
        alu_valid = 1'b1; alu_RobId = 4'd11; alu_value = 32'h11;
        tick(); idle();
        rdy = 1'b0;
        put(0, 1, 0, 0, 1, 0, 4'd3, 32'h308);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("frozen_no_exec", exec_valid, 1'b0);
        end
        idle();
        tick();
        check("thaw_first_pc", exec_pc, 32'h300);
        tick();
        check("thaw_second_pc", exec_pc, 32'h304);
        check("thaw_second_valid", exec_valid, 1'b1);
        #2 rst = 1'b1;
        #1 check("async_rst_drop", exec_valid, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // Randomised traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rdy         = ($urandom_range(0, 7) != 0);
            rollback    = ($urandom_range(0, 63) == 0);
            issue_valid = $urandom_range(0, 1);
            issue_op    = OP_LOG'($urandom);
            issue_Vj    = $urandom; issue_Vk = $urandom;
            issue_Rj    = ($urandom_range(0, 2) == 0); issue_Rk = ($urandom_range(0, 2) == 0);
            issue_Qj    = 4'($urandom_range(0, 7)); issue_Qk = 4'($urandom_range(0, 7));
            issue_imm   = $urandom; issue_pc = $urandom; issue_RobId = 4'($urandom);
            alu_valid   = $urandom_range(0, 1);
            alu_RobId   = 4'($urandom_range(0, 7)); alu_value = $urandom;
            lsb_valid   = $urandom_range(0, 1);
            lsb_RobId   = 4'($urandom_range(0, 7)); lsb_value = $urandom;
            tick();
        end
        idle();
        tick(); tick();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
